// File: rtl/vga_crtc_timing.sv
// rtl/vga_crtc_timing.sv - VGA raster timing: pixel/line counters, syncs, display enables, frame strobe
module vga_crtc_timing #(
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 400,
    parameter int V_FP   = 12,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 35,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on_h,
    output logic       video_on_v,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_crtc_timing: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_crtc_timing: V_TOTAL exceeds 1024");
    end

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END = 10'(H_DISP);
    localparam logic [9:0] V_DISP_END = 10'(V_DISP);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hs_next;
    logic       vs_next;
    logic       von_h_next;
    logic       von_v_next;
    logic       fs_next;

    // Flags decode the next counter values so they land in the same register
    // stage as the counters and never skew against them.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (enable) begin
            if (h_count == H_LAST) begin
                h_next = '0;
                v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
            end else begin
                h_next = h_count + 10'd1;
            end
        end
        hs_next    = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? H_POL : ~H_POL;
        vs_next    = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? V_POL : ~V_POL;
        von_h_next = (h_next < H_DISP_END);
        von_v_next = (v_next < V_DISP_END);
        fs_next    = (h_next == '0) && (v_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count     <= '0;
            v_count     <= '0;
            horiz_sync  <= ~H_POL;
            vert_sync   <= ~V_POL;
            video_on_h  <= 1'b1;
            video_on_v  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h_count     <= h_next;
            v_count     <= v_next;
            horiz_sync  <= hs_next;
            vert_sync   <= vs_next;
            video_on_h  <= von_h_next;
            video_on_v  <= von_v_next;
            frame_start <= fs_next;
        end
    end

endmodule

// File: tb/tb_vga_crtc_timing.sv
// tb/tb_vga_crtc_timing.sv - randomized-enable bench for vga_crtc_timing against a pixel-index model
module tb_vga_crtc_timing;

    localparam int H_DISP = 20;
    localparam int H_FP   = 3;
    localparam int H_SYNC = 5;
    localparam int H_BP   = 4;
    localparam int V_DISP = 10;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam bit H_POL  = 1'b0;
    localparam bit V_POL  = 1'b1;

    localparam int HT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int VT = V_DISP + V_FP + V_SYNC + V_BP;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       horiz_sync;
    logic       vert_sync;
    logic       video_on_h;
    logic       video_on_v;
    logic       frame_start;

    int checks;
    int errors;
    int p;

    vga_crtc_timing #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .h_count(h_count),
        .v_count(v_count),
        .horiz_sync(horiz_sync),
        .vert_sync(vert_sync),
        .video_on_h(video_on_h),
        .video_on_v(video_on_v),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (pixel index %0d)", tag, obs, exp_v, p);
        end
    endtask

    // Model: everything follows from how many enabled cycles have elapsed since reset.
    task automatic check_model();
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        check("h_count", 32'(h_count), 32'(h));
        check("v_count", 32'(v_count), 32'(v));
        check("horiz_sync", 32'(horiz_sync),
              32'((h >= H_DISP + H_FP && h < H_DISP + H_FP + H_SYNC) ? H_POL : !H_POL));
        check("vert_sync", 32'(vert_sync),
              32'((v >= V_DISP + V_FP && v < V_DISP + V_FP + V_SYNC) ? V_POL : !V_POL));
        check("video_on_h", 32'(video_on_h), 32'(h < H_DISP));
        check("video_on_v", 32'(video_on_v), 32'(v < V_DISP));
        check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_h"}, 32'(h_count), 32'd0);
        check({tag, "_v"}, 32'(v_count), 32'd0);
        check({tag, "_hs"}, 32'(horiz_sync), 32'(!H_POL));
        check({tag, "_vs"}, 32'(vert_sync), 32'(!V_POL));
        check({tag, "_von_h"}, 32'(video_on_h), 32'd1);
        check({tag, "_von_v"}, 32'(video_on_v), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd1);
    endtask

    // Entered and left at a falling edge: check, drive, take one rising edge.
    task automatic step(input bit en);
        check_model();
        enable = en;
        @(posedge clk);
        if (en) p++;
        @(negedge clk);
    endtask

    initial begin
        int th, tv, last_wrap, wraps, period, cyc, fs_cnt;
        logic [9:0] prev_h;
        checks = 0;
        errors = 0;
        p      = 0;
        rst_n  = 1'b0;
        enable = 1'b0;

        // Reset held while enable toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable = i[0];
            check_reset_values("rst_hold");
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        step(1'b1);
        check("first_h", 32'(h_count), 32'd1);
        check("first_fs", 32'(frame_start), 32'd0);

        // Random enable over several frames; count frame_start entries.
        fs_cnt = 0;
        for (int i = 0; i < 4 * HT * VT; i++) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            if (en && p % (HT * VT) == HT * VT - 1) fs_cnt++;
            step(en);
        end
        check("frame_wraps", 32'(fs_cnt), 32'(p / (HT * VT)));

        // 1-in-2 enable: line period in clocks must be twice the pixel count.
        last_wrap = -1;
        wraps     = 0;
        period    = -1;
        cyc       = 0;
        prev_h    = h_count;
        for (int i = 0; i < 6 * HT && wraps < 3; i++) begin
            step(i[0] == 1'b0);
            cyc++;
            if (h_count == 10'd0 && prev_h != 10'd0) begin
                if (last_wrap >= 0) period = cyc - last_wrap;
                last_wrap = cyc;
                wraps++;
            end
            prev_h = h_count;
        end
        check("line_period_half_rate", 32'(period), 32'(2 * HT));

        // Park inside both sync windows, then assert reset between edges.
        th = H_DISP + H_FP + 2;
        tv = V_DISP + V_FP;
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (p % HT == th && (p / HT) % VT == tv) break;
            step(1'b1);
        end
        check_model();
        check("park_h", 32'(h_count), 32'(th));
        check("park_v", 32'(v_count), 32'(tv));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        p = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        check("post_rst_h", 32'(h_count), 32'd1);
        for (int i = 0; i < HT + 3; i++) step(1'b1);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
